// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: accepts one load/store, answers after
// latency_p cycles and holds the response until the core takes it with yumi_i.
module data_mem_responder #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        wen_i,
  input  logic        byte_not_word_i,
  input  logic [31:0] write_data_i,
  input  logic [31:0] addr_i,
  input  logic        yumi_i,
  output logic        yumi_o,
  output logic        valid_o,
  output logic [31:0] read_data_o,
  output logic        error_o,
  output logic [1:0]  state_o
);

  // Handshake: request fires in a cycle where valid_i && yumi_o (IDLE only);
  // response fires in a cycle where valid_o && yumi_i (RESP only). Either side
  // ignores its partner's signal outside those states.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (latency_p >= 2) ? 4'(latency_p - 2) : 4'd0;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_mem [0:(1 << addr_width_p) - 1];

  logic                    w_accept;
  logic [addr_width_p-1:0] w_widx;
  logic [1:0]              w_lane;
  logic                    w_misaligned;
  logic [31:0]             w_word;
  logic [31:0]             w_load_data;
  logic                    w_unused_addr;

  assign w_widx        = addr_i[addr_width_p+1:2];
  assign w_lane        = addr_i[1:0];
  assign w_unused_addr = ^addr_i[31:addr_width_p+2];
  assign w_misaligned  = !byte_not_word_i && (w_lane != 2'd0);
  assign w_word        = r_mem[w_widx];
  // Gated by reset so yumi_o is forced low while reset is held.
  assign w_accept      = reset && (r_state == S_IDLE) && valid_i;

  always_comb begin
    w_load_data = 32'd0;
    if (!wen_i && !w_misaligned) begin
      if (byte_not_word_i) begin
        case (w_lane)
          2'd0:    w_load_data = {24'd0, w_word[7:0]};
          2'd1:    w_load_data = {24'd0, w_word[15:8]};
          2'd2:    w_load_data = {24'd0, w_word[23:16]};
          default: w_load_data = {24'd0, w_word[31:24]};
        endcase
      end else begin
        w_load_data = w_word;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept && wen_i && !w_misaligned) begin
      if (byte_not_word_i) begin
        case (w_lane)
          2'd0:    r_mem[w_widx][7:0]   <= write_data_i[7:0];
          2'd1:    r_mem[w_widx][15:8]  <= write_data_i[7:0];
          2'd2:    r_mem[w_widx][23:16] <= write_data_i[7:0];
          default: r_mem[w_widx][31:24] <= write_data_i[7:0];
        endcase
      end else begin
        r_mem[w_widx] <= write_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CNT_INIT;
      r_rdata <= w_load_data;
      if (w_misaligned) begin
        r_error <= 1'b1;
      end
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (latency_p > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (yumi_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    yumi_o      = w_accept;
    valid_o     = (r_state == S_RESP);
    read_data_o = (r_state == S_RESP) ? r_rdata : 32'd0;
    error_o     = r_error;
    state_o     = r_state;
  end

endmodule
